// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - alarm clock controller: 24 h timekeeping, alarm setting, ring and snooze sequencing
// Define BUZZER_PULSE_EN for a 1 s on / 1 s off buzzer while ringing; default is a steady buzzer.
module alarm_sequencer #(
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_MAX_SEC = 60,
  parameter int ALARM_RST_HR = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic [1:0] mode,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [4:0] al_hours,
  output logic [5:0] al_minutes,
  output logic       buzzer,
  output logic [2:0] state
);

  localparam logic [2:0] RUN       = 3'd0;
  localparam logic [2:0] SET_TIME  = 3'd1;
  localparam logic [2:0] SET_ALARM = 3'd2;
  localparam logic [2:0] RINGING   = 3'd3;
  localparam logic [2:0] SNOOZE    = 3'd4;

  localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * 60);
  localparam logic [7:0]  RING_LAST = 8'(RING_MAX_SEC - 1);
  localparam logic [4:0]  AL_RST    = 5'(ALARM_RST_HR);

  logic        tick_q;
  logic        step;
  logic [11:0] snz_cnt;
  logic [7:0]  ring_cnt;
  logic [4:0]  hr_nxt;
  logic [5:0]  min_nxt;
  logic [5:0]  sec_nxt;
  logic        hit;
  logic [2:0]  mode_state;

  assign step = tick_in & ~tick_q;

  // Time-of-day one second ahead, with full carry chain
  always_comb begin
    sec_nxt = seconds + 6'd1;
    min_nxt = minutes;
    hr_nxt  = hours;
    if (seconds == 6'd59) begin
      sec_nxt = 6'd0;
      if (minutes == 6'd59) begin
        min_nxt = 6'd0;
        hr_nxt  = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
      end else begin
        min_nxt = minutes + 6'd1;
      end
    end
  end

  assign hit = alarm_en && (hr_nxt == al_hours) && (min_nxt == al_minutes) && (sec_nxt == 6'd0);

  always_comb begin
    mode_state = RUN;
    if (mode == 2'b01)      mode_state = SET_TIME;
    else if (mode == 2'b10) mode_state = SET_ALARM;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q     <= 1'b0;
      hours      <= 5'd0;
      minutes    <= 6'd0;
      seconds    <= 6'd0;
      al_hours   <= AL_RST;
      al_minutes <= 6'd0;
      buzzer     <= 1'b0;
      state      <= RUN;
      snz_cnt    <= 12'd0;
      ring_cnt   <= 8'd0;
    end else begin
      tick_q <= tick_in;
      if (step && state != SET_TIME) begin
        hours   <= hr_nxt;
        minutes <= min_nxt;
        seconds <= sec_nxt;
      end
      case (state)
        RUN, SET_TIME, SET_ALARM: begin
          if (state == SET_TIME) begin
            seconds <= 6'd0;
            if (inc_min) minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
            if (inc_hr)  hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
          end
          if (state == SET_ALARM) begin
            if (inc_min) al_minutes <= (al_minutes == 6'd59) ? 6'd0 : al_minutes + 6'd1;
            if (inc_hr)  al_hours   <= (al_hours == 5'd23) ? 5'd0 : al_hours + 5'd1;
          end
          // Alarm matching is only live in RUN so editing never fires it
          if (state == RUN && step && hit) begin
            state    <= RINGING;
            ring_cnt <= 8'd0;
            buzzer   <= 1'b1;
          end else begin
            state <= mode_state;
          end
        end
        RINGING: begin
          if (!alarm_en || stop) begin
            state  <= RUN;
            buzzer <= 1'b0;
          end else if (snooze) begin
            state   <= SNOOZE;
            snz_cnt <= SNZ_LOAD;
            buzzer  <= 1'b0;
          end else if (step) begin
            ring_cnt <= ring_cnt + 8'd1;
            if (ring_cnt == RING_LAST) begin
              state  <= RUN;
              buzzer <= 1'b0;
            end else begin
`ifdef BUZZER_PULSE_EN
              buzzer <= ~buzzer;
`else
              buzzer <= 1'b1;
`endif
            end
          end
        end
        SNOOZE: begin
          buzzer <= 1'b0;
          if (!alarm_en || stop) begin
            state   <= RUN;
            snz_cnt <= 12'd0;
          end else if (step) begin
            if (snz_cnt <= 12'd1) begin
              state    <= RINGING;
              snz_cnt  <= 12'd0;
              ring_cnt <= 8'd0;
              buzzer   <= 1'b1;
            end else begin
              snz_cnt <= snz_cnt - 12'd1;
            end
          end
        end
        default: begin
          state  <= RUN;
          buzzer <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - directed bench for alarm_sequencer
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_in = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       inc_hr = 1'b0;
  logic       inc_min = 1'b0;
  logic       alarm_en = 1'b0;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [4:0] al_hours;
  logic [5:0] al_minutes;
  logic       buzzer;
  logic [2:0] state;

  int checks = 0;
  int passes = 0;

  alarm_sequencer #(.SNOOZE_MIN(5), .RING_MAX_SEC(60), .ALARM_RST_HR(7)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .mode(mode), .inc_hr(inc_hr),
    .inc_min(inc_min), .alarm_en(alarm_en), .snooze(snooze), .stop(stop),
    .hours(hours), .minutes(minutes), .seconds(seconds), .al_hours(al_hours),
    .al_minutes(al_minutes), .buzzer(buzzer), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_step(input int hi, input int lo);
    @(negedge clk) tick_in = 1'b1;
    repeat (hi) @(negedge clk);
    tick_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic steps(input int n);
    repeat (n) do_step(2, 2);
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk) mode = m;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_inc(input logic hr, input logic mn, input int n);
    repeat (n) begin
      @(negedge clk);
      inc_hr = hr;
      inc_min = mn;
      @(negedge clk);
      inc_hr = 1'b0;
      inc_min = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hours", hours, 0);
    check("rst_minutes", minutes, 0);
    check("rst_seconds", seconds, 0);
    check("rst_al_hours", al_hours, 7);
    check("rst_al_minutes", al_minutes, 0);
    check("rst_buzzer", buzzer, 0);
    check("rst_state", state, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // three long ticks, one step each
    repeat (3) do_step(25, 5);
    check("run3_seconds", seconds, 3);
    check("run3_minutes", minutes, 0);
    check("run3_hours", hours, 0);
    check("run3_buzzer", buzzer, 0);
    check("run3_state", state, 0);

    // set time: 61 minute pulses with a tick rising in the middle
    set_mode(2'b01);
    check("set_state", state, 1);
    for (int i = 0; i < 61; i++) begin
      @(negedge clk);
      inc_min = 1'b1;
      tick_in = (i >= 30 && i < 34);
      @(negedge clk);
      inc_min = 1'b0;
    end
    tick_in = 1'b0;
    @(negedge clk);
    check("set61_minutes", minutes, 1);
    check("set61_hours", hours, 0);
    check("set61_seconds", seconds, 0);

    pulse_inc(1'b1, 1'b1, 1);
    check("both_hours", hours, 1);
    check("both_minutes", minutes, 2);
    pulse_inc(1'b1, 1'b0, 22);
    pulse_inc(1'b0, 1'b1, 57);
    set_mode(2'b00);
    steps(59);
    check("pre_hours", hours, 23);
    check("pre_minutes", minutes, 59);
    check("pre_seconds", seconds, 59);
    steps(1);
    check("wrap_hours", hours, 0);
    check("wrap_minutes", minutes, 0);
    check("wrap_seconds", seconds, 0);

    // 30 hour pulses wrap to 6, then preload 06:59:59
    set_mode(2'b01);
    pulse_inc(1'b1, 1'b0, 30);
    check("hrwrap_hours", hours, 6);
    pulse_inc(1'b0, 1'b1, 59);
    set_mode(2'b00);
    alarm_en = 1'b1;
    steps(59);
    check("pre7_seconds", seconds, 59);
    check("pre7_state", state, 0);

    @(negedge clk) tick_in = 1'b1;
    @(posedge clk);
    #1;
    check("ring_state_edge", state, 3);
    check("ring_hours", hours, 7);
    check("ring_seconds", seconds, 0);
    @(posedge clk);
    #1;
    check("ring_buzzer", buzzer, 1);
    @(negedge clk) tick_in = 1'b0;
    @(negedge clk);

    steps(59);
    check("ring59_state", state, 3);
    check("ring59_buzzer", buzzer, 1);
    steps(1);
    check("timeout_state", state, 0);
    check("timeout_buzzer", buzzer, 0);

    // alarm edit to 07:02, with hour wrap and running time
    set_mode(2'b10);
    pulse_inc(1'b0, 1'b1, 2);
    check("al_minutes_2", al_minutes, 2);
    pulse_inc(1'b1, 1'b0, 17);
    check("al_hours_wrap", al_hours, 0);
    pulse_inc(1'b1, 1'b0, 7);
    check("al_hours_7", al_hours, 7);
    steps(1);
    check("setal_seconds", seconds, 1);
    check("setal_state", state, 2);
    set_mode(2'b00);
    steps(59);
    check("ring2_state", state, 3);

    @(negedge clk);
    stop = 1'b1;
    snooze = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    snooze = 1'b0;
    @(negedge clk);
    check("stopwins_state", state, 0);
    check("stopwins_buzzer", buzzer, 0);

    set_mode(2'b10);
    pulse_inc(1'b0, 1'b1, 1);
    set_mode(2'b00);
    steps(60);
    check("ring3_state", state, 3);

    @(negedge clk) snooze = 1'b1;
    @(negedge clk) snooze = 1'b0;
    @(negedge clk);
    check("snooze_state", state, 4);
    check("snooze_buzzer", buzzer, 0);
    steps(150);
    @(negedge clk) snooze = 1'b1;
    @(negedge clk) snooze = 1'b0;
    steps(149);
    check("snooze299_state", state, 4);
    steps(1);
    check("rering_state", state, 3);
    check("rering_buzzer", buzzer, 1);
    check("rering_hours", hours, 7);
    check("rering_minutes", minutes, 8);
    check("rering_seconds", seconds, 0);

    // asynchronous reset while ringing
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_buzzer", buzzer, 0);
    check("arst_state", state, 0);
    check("arst_hours", hours, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("arst_al_hours", al_hours, 7);
    check("arst_al_minutes", al_minutes, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
